// File: rtl/fb_ps2_kbd_rx_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: frame geometry, FSM
// encodings, the receiver state record and the odd-parity rule.
package fb_ps2_kbd_rx_pkg;

    localparam int FB_PS2_CODE_W     = 8;
    localparam int FB_PS2_FRAME_BITS = 11;
    localparam int FB_PS2_DATA_BITS  = FB_PS2_FRAME_BITS - 3;  // minus start, parity, stop
    localparam int FB_32BITS         = 32;

    typedef enum logic [1:0] {
        FB_PS2_IDLE   = 2'd0,
        FB_PS2_DATA   = 2'd1,
        FB_PS2_PARITY = 2'd2,
        FB_PS2_STOP   = 2'd3
    } ps2_state_e;

    // Receiver FSM state plus data-bit counter, kept together so checkers
    // can observe the whole deframer position from one signal.
    typedef struct packed {
        ps2_state_e state;
        logic [2:0] bit_cnt;
    } ps2_rx_t;

    function automatic logic odd_parity_ok(input logic [FB_PS2_CODE_W-1:0] code,
                                           input logic par);
        return (^code) ^ par;
    endfunction

endpackage

// File: rtl/fb_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; the head is visible on rdata
// (zero when empty) and a push is accepted while full if a pop coincides.
module fb_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr,
    input  logic [W-1:0] wdata,
    input  logic         rd,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          do_rd;
    logic          do_wr;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign do_rd = rd && !empty;
    assign do_wr = wr && (!full || do_rd);
    assign rdata = empty ? '0 : mem[rptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wptr] <= wdata;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_wr) begin
                wptr <= wptr + 1'b1;
            end
            if (do_rd) begin
                rptr <= rptr + 1'b1;
            end
            if (do_wr && !do_rd) begin
                count <= count + 1'b1;
            end else if (do_rd && !do_wr) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/fb_ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronises the lines, deframes 11-bit frames,
// checks odd parity and stop bit, and queues good scan codes in a FIFO.
// Optional partial-frame abort is enabled by defining FB_PS2_TIMEOUT_EN.
module fb_ps2_kbd_rx
    import fb_ps2_kbd_rx_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ps2_clk,
    input  logic                 ps2_data,
    input  logic                 rd,
    input  logic                 ovf_clr,
    output logic [FB_32BITS-1:0] data,
    output logic                 av,
    output logic                 empty,
    output logic                 frame_err,
    output logic                 overflow
);

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("fb_ps2_kbd_rx: unsupported FIFO_DEPTH or TIMEOUT_CYCLES");
    end

    logic [1:0]               clk_sync;
    logic                     clk_s3;
    logic [1:0]               dat_sync;
    logic                     fe;
    logic                     din;
    ps2_rx_t                  rx_q;
    ps2_rx_t                  rx_d;
    logic [FB_PS2_CODE_W-1:0] sr_q;
    logic [FB_PS2_CODE_W-1:0] sr_d;
    logic                     par_q;
    logic                     par_d;
    logic                     frame_done;
    logic                     frame_good;
    logic                     timeout;
    logic                     wr_ok;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [FB_PS2_CODE_W-1:0] head;
    logic                     av_q;
    logic                     ferr_q;
    logic                     ovf_q;

    // Lines idle high, so the synchroniser resets to 1 to avoid a false edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync <= 2'b11;
            clk_s3   <= 1'b1;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            clk_s3   <= clk_sync[1];
            dat_sync <= {dat_sync[0], ps2_data};
        end
    end

    assign fe  = !clk_sync[1] && clk_s3;
    assign din = dat_sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_q  <= '{state: FB_PS2_IDLE, bit_cnt: 3'd0};
            sr_q  <= '0;
            par_q <= 1'b0;
        end else begin
            rx_q  <= rx_d;
            sr_q  <= sr_d;
            par_q <= par_d;
        end
    end

    always_comb begin
        rx_d       = rx_q;
        sr_d       = sr_q;
        par_d      = par_q;
        frame_done = 1'b0;
        frame_good = 1'b0;
        if (timeout) begin
            rx_d = '{state: FB_PS2_IDLE, bit_cnt: 3'd0};
        end else if (fe) begin
            case (rx_q.state)
                FB_PS2_IDLE: begin
                    if (!din) begin
                        rx_d = '{state: FB_PS2_DATA, bit_cnt: 3'd0};
                    end
                end
                FB_PS2_DATA: begin
                    sr_d = {din, sr_q[FB_PS2_CODE_W-1:1]};
                    if (rx_q.bit_cnt == 3'(FB_PS2_DATA_BITS - 1)) begin
                        rx_d.state = FB_PS2_PARITY;
                    end else begin
                        rx_d.bit_cnt = rx_q.bit_cnt + 3'd1;
                    end
                end
                FB_PS2_PARITY: begin
                    par_d      = din;
                    rx_d.state = FB_PS2_STOP;
                end
                default: begin
                    frame_done = 1'b1;
                    frame_good = odd_parity_ok(sr_q, par_q) && din;
                    rx_d       = '{state: FB_PS2_IDLE, bit_cnt: 3'd0};
                end
            endcase
        end
    end

`ifdef FB_PS2_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES);
    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge clk) begin
        if (rst || rx_q.state == FB_PS2_IDLE || fe || timeout) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign timeout = (rx_q.state != FB_PS2_IDLE) && !fe &&
                     (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // A pop in the stop cycle frees a slot even when the FIFO is full.
    assign wr_ok = frame_good && (!fifo_full || (rd && !fifo_empty));

    fb_sync_fifo #(
        .W    (FB_PS2_CODE_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .wr   (wr_ok),
        .wdata(sr_q),
        .rd   (rd),
        .rdata(head),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            av_q   <= 1'b0;
            ferr_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            av_q   <= wr_ok;
            ferr_q <= (frame_done && !frame_good) || timeout;
            if (frame_good && !wr_ok) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign data      = {{(FB_32BITS - FB_PS2_CODE_W){1'b0}}, head};
    assign av        = av_q;
    assign empty     = fifo_empty;
    assign frame_err = ferr_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_fb_ps2_kbd_rx.sv
// Bench for fb_ps2_kbd_rx: directed frames plus randomized frames, reads and
// flag clears, compared against a queue-based model of the receiver.
module tb_fb_ps2_kbd_rx;

    localparam int DEPTH = 8;

    logic        clk;
    logic        rst;
    logic        ps2_clk;
    logic        ps2_data;
    logic        rd;
    logic        ovf_clr;
    logic [31:0] data;
    logic        av;
    logic        empty;
    logic        frame_err;
    logic        overflow;

    logic [7:0] exp_q[$];
    int         exp_av;
    int         exp_ferr;
    logic       exp_ovf;
    int         av_seen;
    int         ferr_seen;
    int         n_checks;
    int         n_pass;

    fb_ps2_kbd_rx #(
        .FIFO_DEPTH    (DEPTH),
        .TIMEOUT_CYCLES(100000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rd       (rd),
        .ovf_clr  (ovf_clr),
        .data     (data),
        .av       (av),
        .empty    (empty),
        .frame_err(frame_err),
        .overflow (overflow)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // pulse counters; a code entering the FIFO must be visible with av
    always @(negedge clk) begin
        if (!rst) begin
            if (av) begin
                av_seen++;
                check("av_visible", {31'b0, empty}, 32'd0);
            end
            if (frame_err) begin
                ferr_seen++;
            end
        end
    end

    // driver tasks
    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (6) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (6) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            ps2_bit(code[i]);
        end
        ps2_bit(~(^code) ^ bad_par);
        ps2_bit(!bad_stop);
        ps2_data = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic model_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop);
        if (bad_par || bad_stop) begin
            exp_ferr++;
        end else if (exp_q.size() < DEPTH) begin
            exp_q.push_back(code);
            exp_av++;
        end else begin
            exp_ovf = 1'b1;
        end
    endtask

    task automatic frame(input logic [7:0] code, input bit bad_par, input bit bad_stop);
        send_frame(code, bad_par, bad_stop);
        model_frame(code, bad_par, bad_stop);
    endtask

    task automatic check_state(input string tag);
        logic [31:0] exp_data;
        exp_data = (exp_q.size() == 0) ? 32'd0 : {24'd0, exp_q[0]};
        check({tag, "_av"}, av_seen, exp_av);
        check({tag, "_ferr"}, ferr_seen, exp_ferr);
        check({tag, "_empty"}, {31'b0, empty}, {31'b0, exp_q.size() == 0});
        check({tag, "_ovf"}, {31'b0, overflow}, {31'b0, exp_ovf});
        check({tag, "_data"}, data, exp_data);
    endtask

    task automatic read_one(input string tag);
        logic [31:0] exp_data;
        exp_data = (exp_q.size() == 0) ? 32'd0 : {24'd0, exp_q[0]};
        check({tag, "_head"}, data, exp_data);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        if (exp_q.size() != 0) begin
            void'(exp_q.pop_front());
        end
        exp_data = (exp_q.size() == 0) ? 32'd0 : {24'd0, exp_q[0]};
        check({tag, "_next"}, data, exp_data);
    endtask

    task automatic clear_ovf();
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        exp_ovf = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_av", {31'b0, av}, 32'd0);
        check("rst_ferr", {31'b0, frame_err}, 32'd0);
        check("rst_ovf", {31'b0, overflow}, 32'd0);
        check("rst_empty", {31'b0, empty}, 32'd1);
        check("rst_data", data, 32'd0);
        rst = 1'b0;
        exp_q.delete();
        exp_ovf = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        exp_av    = 0;
        exp_ferr  = 0;
        exp_ovf   = 1'b0;
        av_seen   = 0;
        ferr_seen = 0;
        ps2_clk   = 1'b1;
        ps2_data  = 1'b1;
        rd        = 1'b0;
        ovf_clr   = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        do_reset();

        frame(8'h1C, 1'b0, 1'b0);
        check_state("single");
        read_one("single_rd");
        check_state("single_drained");

        frame(8'hF0, 1'b0, 1'b0);
        frame(8'h1C, 1'b0, 1'b0);
        check_state("pair");
        read_one("pair_rd0");
        read_one("pair_rd1");

        frame(8'h1C, 1'b1, 1'b0);
        check_state("bad_parity");
        frame(8'h1C, 1'b0, 1'b1);
        check_state("bad_stop");

        for (int i = 1; i <= 9; i++) begin
            frame(8'(i), 1'b0, 1'b0);
        end
        check_state("overflow");
        for (int i = 0; i < 8; i++) begin
            read_one("ovf_rd");
        end
        read_one("rd_when_empty");
        clear_ovf();
        check_state("ovf_cleared");

        // abandon a frame after four data bits, then reset
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) begin
            ps2_bit(1'b1);
        end
        do_reset();
        frame(8'h5A, 1'b0, 1'b0);
        check_state("after_reset");
        read_one("after_reset_rd");

        for (int n = 0; n < 45; n++) begin
            logic [7:0] code;
            bit         bp;
            bit         bs;
            code = 8'($urandom_range(0, 255));
            bp   = ($urandom_range(0, 5) == 0);
            bs   = ($urandom_range(0, 7) == 0);
            frame(code, bp, bs);
            check_state("rand_frame");
            if ($urandom_range(0, 2) == 0) begin
                for (int k = $urandom_range(1, 3); k > 0; k--) begin
                    read_one("rand_rd");
                end
            end
            if ($urandom_range(0, 5) == 0) begin
                clear_ovf();
                check_state("rand_clr");
            end
        end

        while (exp_q.size() != 0) begin
            read_one("final_drain");
        end
        check_state("final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
